// File: rtl/crc16_pkg.sv
// Shared constants and types for the serial CRC-16 (poly 0x8005) encoder/checker pair.
package crc16_pkg;

    localparam int          CRC_W    = 16;
    localparam logic [15:0] CRC_POLY = 16'h8005;
    localparam logic [15:0] CRC_INIT = 16'h0000;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        CHECK,
        DONE
    } crc_chk_state_t;

endpackage

// File: rtl/crc16_lfsr_step.sv
// One MSB-first step of the CRC-16 LFSR; combinational, shared with the serial encoder.
module crc16_lfsr_step
    import crc16_pkg::*;
(
    input  logic [CRC_W-1:0] lfsr_i,
    input  logic             bit_i,
    output logic [CRC_W-1:0] lfsr_next_o
);

    logic fb;

    assign fb          = lfsr_i[CRC_W-1] ^ bit_i;
    assign lfsr_next_o = {lfsr_i[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);

endmodule

// File: rtl/crc16_serial_checker.sv
// Serial CRC-16 receive checker: deserialises DATA_LEN message bits, checks 16 CRC bits.
// Optional error counter output err_count enabled by defining CRC16_ERR_CNT_EN.
module crc16_serial_checker
    import crc16_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int CNT_W    = $clog2(DATA_LEN + 16) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                bit_valid,
    input  logic                bit_in,
    output logic                busy,
    output logic [DATA_LEN-1:0] data_out,
    output logic                done,
    output logic                crc_ok,
`ifdef CRC16_ERR_CNT_EN
    output logic                crc_err,
    output logic [15:0]         err_count
`else
    output logic                crc_err
`endif
);

    crc_chk_state_t      state_q, state_d;
    logic [CRC_W-1:0]    lfsr_q, lfsr_d, lfsr_step;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_LEN-1:0] data_q, data_d;
    logic                ok_q, ok_d;
    logic                err_q, err_d;

    crc16_lfsr_step u_step (
        .lfsr_i      (lfsr_q),
        .bit_i       (bit_in),
        .lfsr_next_o (lfsr_step)
    );

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        ok_d    = ok_q;
        err_d   = err_q;

        case (state_q)
            DATA: begin
                if (bit_valid) begin
                    lfsr_d = lfsr_step;
                    data_d = (data_q << 1) | DATA_LEN'(bit_in);
                    if (cnt_q == CNT_W'(DATA_LEN - 1)) begin
                        state_d = CHECK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            CHECK: begin
                if (bit_valid) begin
                    lfsr_d = lfsr_step;
                    if (cnt_q == CNT_W'(CRC_W - 1)) begin
                        // Verdict is latched here so it is visible alongside done.
                        state_d = DONE;
                        cnt_d   = '0;
                        ok_d    = (lfsr_step == '0);
                        err_d   = (lfsr_step != '0);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = state_q;
        endcase

        // start overrides everything, including a bit arriving in the same cycle.
        if (start) begin
            state_d = DATA;
            lfsr_d  = CRC_INIT;
            cnt_d   = '0;
            data_d  = data_q;
            ok_d    = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            lfsr_q  <= CRC_INIT;
            cnt_q   <= '0;
            data_q  <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    assign busy     = (state_q == DATA) || (state_q == CHECK);
    assign done     = (state_q == DONE);
    assign data_out = data_q;
    assign crc_ok   = ok_q;
    assign crc_err  = err_q;

`ifdef CRC16_ERR_CNT_EN
    logic [15:0] errcnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            errcnt_q <= '0;
        end else if ((state_q == DONE) && err_q && (errcnt_q != 16'hFFFF)) begin
            errcnt_q <= errcnt_q + 16'd1;
        end
    end

    assign err_count = errcnt_q;
`endif

endmodule

// File: tb/tb_crc16_serial_checker.sv
// Directed bench for crc16_serial_checker with DATA_LEN=32 and DATA_LEN=72 instances.
module tb_crc16_serial_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, bit_valid, bit_in, sel72;

    logic        busy32, done32, ok32, err32;
    logic [31:0] data32;
    logic        busy72, done72, ok72, err72;
    logic [71:0] data72;
`ifdef CRC16_ERR_CNT_EN
    logic [15:0] errcnt32, errcnt72;
`endif

    int checks = 0;
    int errors = 0;
    int dn32 = 0;
    int dn72 = 0;

    crc16_serial_checker #(.DATA_LEN(32)) u_dut32 (
        .clk       (clk),
        .rst       (rst),
        .start     (start && !sel72),
        .bit_valid (bit_valid && !sel72),
        .bit_in    (bit_in),
        .busy      (busy32),
        .data_out  (data32),
        .done      (done32),
        .crc_ok    (ok32),
`ifdef CRC16_ERR_CNT_EN
        .crc_err   (err32),
        .err_count (errcnt32)
`else
        .crc_err   (err32)
`endif
    );

    crc16_serial_checker #(.DATA_LEN(72)) u_dut72 (
        .clk       (clk),
        .rst       (rst),
        .start     (start && sel72),
        .bit_valid (bit_valid && sel72),
        .bit_in    (bit_in),
        .busy      (busy72),
        .data_out  (data72),
        .done      (done72),
        .crc_ok    (ok72),
`ifdef CRC16_ERR_CNT_EN
        .crc_err   (err72),
        .err_count (errcnt72)
`else
        .crc_err   (err72)
`endif
    );

    logic        s_busy, s_done, s_ok, s_err;
    logic [71:0] s_data;
    assign s_busy = sel72 ? busy72 : busy32;
    assign s_done = sel72 ? done72 : done32;
    assign s_ok   = sel72 ? ok72   : ok32;
    assign s_err  = sel72 ? err72  : err32;
    assign s_data = sel72 ? data72 : {40'd0, data32};

    always @(posedge clk) begin
        if (done32) dn32 <= dn32 + 1;
        if (done72) dn72 <= dn72 + 1;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Start pulse with a valid '1' bit alongside; that bit must be discarded.
    task automatic pulse_start();
        start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        @(negedge clk);
        start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    endtask

    task automatic send(input logic [127:0] w, input int n, input bit gaps);
        for (int i = n - 1; i >= 0; i--) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                repeat (g) begin
                    bit_valid = 1'b0;
                    @(negedge clk);
                end
            end
            bit_valid = 1'b1;
            bit_in    = w[i];
            @(negedge clk);
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    // Called at the negedge of the DONE cycle; leaves the selected DUT idle.
    task automatic finish(input string tag, input logic ok, input logic [71:0] data);
        chk({tag, "_done"}, s_done, 1'b1);
        chk({tag, "_ok"},   s_ok,   ok);
        chk({tag, "_err"},  s_err,  !ok);
        chk({tag, "_data"}, s_data, data);
        @(negedge clk);
        chk({tag, "_done_low"}, s_done, 1'b0);
        chk({tag, "_ok_held"},  s_ok,   ok);
        chk({tag, "_idle"},     s_busy, 1'b0);
    endtask

    logic [47:0] w_good, w_bad;
    logic [87:0] w72;
    int base;

    initial begin
        rst = 1'b0; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; sel72 = 1'b0;
        w_good = {32'h0000_0001, 16'h8005};
        w_bad  = {32'h0000_0001, 16'h8004};
        w72    = {72'h31_3233_3435_3637_3839, 16'hFEE8};

        repeat (2) @(negedge clk);
        chk("rst_busy", busy32, 1'b0);
        chk("rst_done", done32, 1'b0);
        chk("rst_ok",   ok32,   1'b0);
        chk("rst_err",  err32,  1'b0);
        chk("rst_data", data32, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        base = dn32;
        pulse_start();
        send({32'h0, 16'h0}, 48, 1'b0);
        finish("zero", 1'b1, 72'h0);
        chk("zero_pulses", dn32 - base, 1);

        pulse_start();
        send(w_good, 48, 1'b0);
        finish("one", 1'b1, 72'h1);

        pulse_start();
        send(w_bad, 48, 1'b0);
        finish("one_bad", 1'b0, 72'h1);

        sel72 = 1'b1;
        pulse_start();
        send(w72, 88, 1'b0);
        finish("ascii", 1'b1, 72'h31_3233_3435_3637_3839);
        pulse_start();
        send(w72 ^ (88'd1 << 50), 88, 1'b0);
        finish("ascii_flip_data", 1'b0, 72'h31_3233_3435_3637_3839 ^ (72'd1 << 34));
        pulse_start();
        send(w72 ^ (88'd1 << 3), 88, 1'b0);
        finish("ascii_flip_crc", 1'b0, 72'h31_3233_3435_3637_3839);
        sel72 = 1'b0;
        chk("dut32_untouched", data32, 32'h1);

        base = dn32;
        pulse_start();
        send(w_good, 48, 1'b1);
        finish("gaps", 1'b1, 72'h1);
        chk("gaps_pulses", dn32 - base, 1);

        base = dn32;
        pulse_start();
        send(w_good >> 38, 10, 1'b0);
        chk("abort_busy", busy32, 1'b1);
        pulse_start();
        send(w_good, 48, 1'b0);
        finish("abort", 1'b1, 72'h1);
        chk("abort_pulses", dn32 - base, 1);

        // Back-to-back: start lands in the DONE cycle of a failing frame.
        pulse_start();
        send(w_bad, 48, 1'b0);
        chk("b2b_done", done32, 1'b1);
        chk("b2b_err",  err32,  1'b1);
        pulse_start();
        chk("b2b_busy",    busy32, 1'b1);
        chk("b2b_err_clr", err32,  1'b0);
        send(w_good, 48, 1'b0);
        finish("b2b", 1'b1, 72'h1);

        pulse_start();
        base = dn32;
        send(w_good >> 11, 37, 1'b0);
        chk("mid_busy", busy32, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", busy32, 1'b0);
        chk("arst_done", done32, 1'b0);
        chk("arst_ok",   ok32,   1'b0);
        chk("arst_err",  err32,  1'b0);
        chk("arst_data", data32, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("arst_pulses", dn32 - base, 0);
        pulse_start();
        send(w_good, 48, 1'b0);
        finish("post_rst", 1'b1, 72'h1);

`ifdef CRC16_ERR_CNT_EN
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("errcnt_rst", errcnt32, 16'd0);
        repeat (3) begin
            pulse_start();
            send(w_bad, 48, 1'b0);
            finish("errcnt_frame", 1'b0, 72'h1);
        end
        chk("errcnt_three", errcnt32, 16'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc16_serial_checker.md
Name: crc16_serial_checker

Overview:
- Receive-side companion to the serial CRC-16 encoder. It consumes the serial code word: DATA_LEN message bits, then 16 CRC bits, MSB-first.
- It deserialises the message, recomputes the CRC over the whole code word, and flags pass/fail.
- Generator polynomial x^16+x^15+x^2+1 (0x8005). Register initialised to zero, no reflection, no final XOR.
- Sits between the serial link receiver and the frame consumer.

Parameters:
- DATA_LEN, 32, number of message bits per frame (legal range 1..1024).
- CNT_W, $clog2(DATA_LEN+16)+1, width of the internal bit counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a new frame; clears the LFSR and counter.
- bit_valid  in  1  qualifies bit_in. Gaps between valid bits are allowed.
- bit_in  in  1  serial code-word bit, MSB-first.
- busy  out  1  high while in DATA or CHECK.
- data_out  out  DATA_LEN  deserialised message; first received bit lands in the MSB.
- done  out  1  one-cycle pulse when a frame completes.
- crc_ok  out  1  remainder was zero; held until the next start.
- crc_err  out  1  remainder was non-zero; held until the next start.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; LFSR=0; count=0.
  - busy=0, data_out=0, done=0, crc_ok=0, crc_err=0.
  - Reset mid-frame discards the frame; no done pulse is issued.
- FSM states: IDLE, DATA, CHECK, DONE.
  - IDLE: start=1 -> DATA. LFSR, count, crc_ok and crc_err are cleared on the same edge.
  - DATA: each bit_valid=1 performs one LFSR step, shifts bit_in into the LSB of data_out, and increments count.
    - When the DATA_LEN-th bit is accepted -> CHECK, with count reset to 0.
  - CHECK: each bit_valid=1 performs one LFSR step only; data_out is held.
    - When the 16th CRC bit is accepted -> DONE.
  - DONE (one cycle):
    - done=1.
    - crc_ok = (LFSR==0); crc_err = !crc_ok.
    - Next state IDLE.
- LFSR step with feedback f = lfsr[15]^bit_in:
  - lfsr[0] <= f
  - lfsr[1] <= lfsr[0]
  - lfsr[2] <= lfsr[1]^f
  - lfsr[14:3] <= lfsr[13:2]
  - lfsr[15] <= lfsr[14]^f
- Latency: done is asserted in the cycle after the edge that accepts the final CRC bit.
- bit_valid=0 in DATA or CHECK: all state is held; there is no timeout.
- bit_valid outside DATA/CHECK: ignored.
- start while busy=1: aborts the frame and restarts exactly as from IDLE. No done pulse for the aborted frame.
- start in DONE: takes priority; DONE completes its outputs, then the FSM goes to DATA rather than IDLE.
- start and bit_valid in the same cycle: start wins; that bit is discarded.
- Counter rules:
  - count never exceeds DATA_LEN-1 in DATA and never exceeds 15 in CHECK.
  - No wrap-around is reachable.

Optional Feature:
- Macro: CRC16_ERR_CNT_EN.
- Defined:
  - Adds output err_count [15:0], reset 0.
  - Increments in the DONE cycle when crc_err is set.
  - Saturates at 0xFFFF; cleared only by rst.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Package crc16_pkg:
  - CRC_W=16, CRC_POLY=16'h8005, CRC_INIT=16'h0000.
  - State enum type crc_chk_state_t (IDLE/DATA/CHECK/DONE).
- Sub-module crc16_lfsr_step: purely combinational next-LFSR function (lfsr, bit_in -> lfsr_next).
  - Shared with the encoder for consistency.

Test Plan:
- DATA_LEN=32; data 0x00000000 followed by CRC 0x0000 -> done pulse, crc_ok=1, crc_err=0, data_out=0x00000000.
- DATA_LEN=32; data 0x00000001 followed by CRC 0x8005 -> crc_ok=1, data_out=0x00000001.
  - Same frame with CRC 0x8004 -> crc_err=1.
- DATA_LEN=72; ASCII "123456789" MSB-first followed by CRC 0xFEE8 -> crc_ok=1.
  - Flip any single bit of the frame -> crc_err=1.
- Stimulus and responses for the remaining checks:
  - Random bit_valid gaps (about 50% duty) on the 0x00000001/0x8005 frame -> same results, done asserted exactly once.
  - start reasserted after 10 bits, then a full valid frame -> only one done pulse, crc_ok=1.
- rst driven low mid-CHECK -> all outputs 0 immediately, no done pulse.
  - A following clean frame -> crc_ok=1.
  - With CRC16_ERR_CNT_EN defined, 3 bad frames -> err_count=3.
